// File: rtl/network_rx_link_arbiter.sv
// Receive-side link arbiter: selects between a preferred (SFP/BASE-R) and an
// alternate (BASE-T) Ethernet receive port, with holdoff before returning to
// the preferred port and clean frame-boundary handling on every switch.

package network_rx_link_arbiter_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BV_W   = 4;

  typedef struct packed {
    logic              start;
    logic              data_valid;
    logic [BV_W-1:0]   bytes_valid;
    logic [DATA_W-1:0] data;
    logic              commit;
    logic              drop;
  } EthernetRxBus;
endpackage

module network_rx_link_arbiter
  import network_rx_link_arbiter_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 250000
) (
  input  logic         clk_250mhz,
  input  logic         rst,
  input  logic         pref_link_up,
  input  EthernetRxBus pref_rx_bus,
  input  logic         alt_link_up,
  input  EthernetRxBus alt_rx_bus,
  output logic         eth_link_up,
  output EthernetRxBus eth_rx_bus,
  output logic [1:0]   active_port,
  output logic [15:0]  switch_count,
  output logic [15:0]  truncated_count
);

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_PREF = 2'd1;
  localparam logic [1:0] SEL_ALT  = 2'd2;

  typedef enum logic [2:0] {
    ST_NONE,
    ST_PREF,
    ST_ALT,
    ST_HOLD_ALT,
    ST_DRAIN_ALT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pref_open_q, alt_open_q;
  logic              out_open_q, out_open_d;
  logic              suppress_q, suppress_d;
  EthernetRxBus      bus_q, bus_d;
  logic              link_up_q;
  logic [1:0]        active_q;
  logic [15:0]       switch_q, trunc_q;

  logic [1:0]        sel_q_c, sel_d_c;
  logic              change_c;
  logic              sw_inc_c, trunc_inc_c;
  EthernetRxBus      src_c;

  // Port currently owned by a given state.
  function automatic logic [1:0] sel_of(state_t s);
    case (s)
      ST_PREF:                          return SEL_PREF;
      ST_ALT, ST_HOLD_ALT, ST_DRAIN_ALT: return SEL_ALT;
      default:                          return SEL_NONE;
    endcase
  endfunction

  // Frame-open tracking: commit/drop closes, start opens, otherwise hold.
  function automatic logic frame_next(logic open_q, EthernetRxBus b);
    if (b.commit || b.drop) return 1'b0;
    if (b.start)            return 1'b1;
    return open_q;
  endfunction

  // Next-state and holdoff counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_NONE: begin
        if (pref_link_up)     state_d = ST_PREF;
        else if (alt_link_up) state_d = ST_ALT;
      end
      ST_PREF: begin
        if (!pref_link_up) state_d = alt_link_up ? ST_ALT : ST_NONE;
      end
      ST_ALT: begin
        if (!alt_link_up) begin
          state_d = pref_link_up ? ST_PREF : ST_NONE;
        end else if (pref_link_up) begin
          state_d = ST_HOLD_ALT;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD_ALT: begin
        if (!alt_link_up) begin
          state_d = pref_link_up ? ST_PREF : ST_NONE;
          cnt_d   = '0;
        end else if (!pref_link_up) begin
          state_d = ST_ALT;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_DRAIN_ALT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DRAIN_ALT: begin
        if (!alt_link_up) begin
          state_d = pref_link_up ? ST_PREF : ST_NONE;
        end else if (!pref_link_up) begin
          state_d = ST_ALT;
        end else if (!alt_open_q && !alt_rx_bus.start) begin
          state_d = ST_PREF;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  // Output word selection: forward, suppress, or force a drop on a lost frame.
  always_comb begin
    sel_q_c     = sel_of(state_q);
    sel_d_c     = sel_of(state_d);
    change_c    = (sel_q_c != sel_d_c);
    sw_inc_c    = change_c && (sel_d_c != SEL_NONE);
    trunc_inc_c = 1'b0;
    suppress_d  = suppress_q;
    bus_d       = '0;
    case (sel_q_c)
      SEL_PREF: src_c = pref_rx_bus;
      SEL_ALT:  src_c = alt_rx_bus;
      default:  src_c = '0;
    endcase
    if (change_c) begin
      suppress_d = 1'b1;
      if (out_open_q) begin
        bus_d.drop  = 1'b1;
        trunc_inc_c = 1'b1;
      end
    end else if (sel_q_c != SEL_NONE) begin
      if (!suppress_q || src_c.start) begin
        bus_d       = src_c;
        bus_d.start = src_c.start & ~out_open_q;
        if (src_c.start) suppress_d = 1'b0;
      end
    end
    out_open_d = frame_next(out_open_q, bus_d);
  end

  // State, counters, per-port frame flags and registered outputs.
  always_ff @(posedge clk_250mhz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_NONE;
      cnt_q       <= '0;
      pref_open_q <= 1'b0;
      alt_open_q  <= 1'b0;
      out_open_q  <= 1'b0;
      suppress_q  <= 1'b0;
      bus_q       <= '0;
      link_up_q   <= 1'b0;
      active_q    <= SEL_NONE;
      switch_q    <= '0;
      trunc_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pref_open_q <= frame_next(pref_open_q, pref_rx_bus);
      alt_open_q  <= frame_next(alt_open_q, alt_rx_bus);
      out_open_q  <= out_open_d;
      suppress_q  <= suppress_d;
      bus_q       <= bus_d;
      link_up_q   <= (sel_d_c != SEL_NONE);
      active_q    <= sel_d_c;
      if (sw_inc_c && (switch_q != CNT_MAX))   switch_q <= switch_q + 16'd1;
      if (trunc_inc_c && (trunc_q != CNT_MAX)) trunc_q  <= trunc_q + 16'd1;
    end
  end

  assign eth_rx_bus      = bus_q;
  assign eth_link_up     = link_up_q;
  assign active_port     = active_q;
  assign switch_count    = switch_q;
  assign truncated_count = trunc_q;

endmodule

// File: tb/tb_network_rx_link_arbiter.sv
// Directed testbench for network_rx_link_arbiter.

module tb_network_rx_link_arbiter;
  import network_rx_link_arbiter_pkg::*;

  localparam int unsigned HOLD = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pref_up = 1'b0;
  logic         alt_up = 1'b0;
  EthernetRxBus pref_bus;
  EthernetRxBus alt_bus;
  EthernetRxBus out_bus;
  logic         link_up;
  logic [1:0]   act;
  logic [15:0]  sw;
  logic [15:0]  tr;

  int checks = 0;
  int errors = 0;

  always #2 clk = ~clk;

  network_rx_link_arbiter #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk_250mhz     (clk),
    .rst            (rst),
    .pref_link_up   (pref_up),
    .pref_rx_bus    (pref_bus),
    .alt_link_up    (alt_up),
    .alt_rx_bus     (alt_bus),
    .eth_link_up    (link_up),
    .eth_rx_bus     (out_bus),
    .active_port    (act),
    .switch_count   (sw),
    .truncated_count(tr)
  );

  function automatic EthernetRxBus w(logic s, logic [63:0] d, logic c);
    EthernetRxBus b;
    b             = '0;
    b.start       = s;
    b.data_valid  = 1'b1;
    b.bytes_valid = 4'd8;
    b.data        = d;
    b.commit      = c;
    return b;
  endfunction

  function automatic EthernetRxBus drop_only();
    EthernetRxBus b;
    b      = '0;
    b.drop = 1'b1;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pref_up = 1'b1; alt_up = 1'b1;
    pref_bus = w(1'b1, 64'h11, 1'b0); alt_bus = w(1'b1, 64'h22, 1'b0);
    repeat (3) tick();
    checks++; if (act !== 2'd0) begin errors++; $display("FAIL reset_act got %0d exp 0", act); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link got %b exp 0", link_up); end
    checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL reset_bus got %h exp 0", out_bus); end
    checks++; if (sw !== 16'd0) begin errors++; $display("FAIL reset_sw got %0d exp 0", sw); end
    checks++; if (tr !== 16'd0) begin errors++; $display("FAIL reset_tr got %0d exp 0", tr); end
  endtask

  task automatic test_pref_frame();
    EthernetRxBus e;
    pref_bus = '0; alt_bus = '0;
    rst = 1'b0;
    tick();
    checks++; if (act !== 2'd1) begin errors++; $display("FAIL pf_act got %0d exp 1", act); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL pf_link got %b exp 1", link_up); end
    checks++; if (sw !== 16'd1) begin errors++; $display("FAIL pf_sw got %0d exp 1", sw); end
    for (int i = 0; i < 16; i++) begin
      e = w(i == 0, 64'hA000 + 64'(i), i == 15);
      pref_bus = e;
      tick();
      checks++; if (out_bus !== e) begin errors++; $display("FAIL pf_word%0d got %h exp %h", i, out_bus, e); end
    end
    pref_bus = '0;
    tick();
    checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL pf_idle got %h exp 0", out_bus); end
  endtask

  task automatic test_pref_drop();
    EthernetRxBus e;
    for (int i = 0; i < 6; i++) begin
      e = w(i == 0, 64'hB000 + 64'(i), 1'b0);
      pref_bus = e;
      alt_bus  = w(i == 0, 64'hC000 + 64'(i), 1'b0);
      if (i == 5) pref_up = 1'b0;
      tick();
      if (i < 5) begin
        checks++; if (out_bus !== e) begin errors++; $display("FAIL pd_word%0d got %h exp %h", i, out_bus, e); end
      end
    end
    checks++; if (out_bus !== drop_only()) begin errors++; $display("FAIL pd_drop got %h exp %h", out_bus, drop_only()); end
    checks++; if (tr !== 16'd1) begin errors++; $display("FAIL pd_tr got %0d exp 1", tr); end
    checks++; if (act !== 2'd2) begin errors++; $display("FAIL pd_act got %0d exp 2", act); end
    checks++; if (sw !== 16'd2) begin errors++; $display("FAIL pd_sw got %0d exp 2", sw); end
    pref_bus = '0;
    for (int j = 6; j < 9; j++) begin
      alt_bus = w(1'b0, 64'hC000 + 64'(j), j == 8);
      tick();
      checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL pd_supp%0d got %h exp 0", j, out_bus); end
    end
    alt_bus = '0;
    tick();
    for (int j = 0; j < 3; j++) begin
      e = w(j == 0, 64'hD000 + 64'(j), j == 2);
      alt_bus = e;
      tick();
      checks++; if (out_bus !== e) begin errors++; $display("FAIL pd_alt%0d got %h exp %h", j, out_bus, e); end
    end
    alt_bus = '0;
    tick();
  endtask

  task automatic test_holdoff_frame();
    EthernetRxBus e;
    rst = 1'b1; pref_up = 1'b0; alt_up = 1'b1; pref_bus = '0; alt_bus = '0;
    tick(); tick();
    checks++; if (sw !== 16'd0 || tr !== 16'd0) begin errors++; $display("FAIL ho_rst got sw=%0d tr=%0d exp 0 0", sw, tr); end
    rst = 1'b0;
    tick();
    checks++; if (act !== 2'd2) begin errors++; $display("FAIL ho_act got %0d exp 2", act); end
    checks++; if (sw !== 16'd1) begin errors++; $display("FAIL ho_sw1 got %0d exp 1", sw); end
    e = w(1'b1, 64'hE000, 1'b0);
    alt_bus = e;
    tick();
    checks++; if (out_bus !== e) begin errors++; $display("FAIL ho_start got %h exp %h", out_bus, e); end
    pref_up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      e = w(1'b0, 64'hE000 + 64'(k), 1'b0);
      alt_bus = e;
      tick();
      checks++; if (act !== 2'd2) begin errors++; $display("FAIL ho_hold%0d got %0d exp 2", k, act); end
      checks++; if (out_bus !== e) begin errors++; $display("FAIL ho_word%0d got %h exp %h", k, out_bus, e); end
    end
    e = w(1'b0, 64'hE00D, 1'b1);
    alt_bus = e;
    tick();
    checks++; if (out_bus !== e) begin errors++; $display("FAIL ho_commit got %h exp %h", out_bus, e); end
    checks++; if (act !== 2'd2) begin errors++; $display("FAIL ho_drain got %0d exp 2", act); end
    alt_bus = '0;
    tick();
    checks++; if (act !== 2'd1) begin errors++; $display("FAIL ho_sw_act got %0d exp 1", act); end
    checks++; if (sw !== 16'd2) begin errors++; $display("FAIL ho_sw2 got %0d exp 2", sw); end
    checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL ho_idle got %h exp 0", out_bus); end
  endtask

  task automatic test_flap();
    pref_up = 1'b0;
    tick();
    checks++; if (act !== 2'd2) begin errors++; $display("FAIL fl_act got %0d exp 2", act); end
    checks++; if (sw !== 16'd3) begin errors++; $display("FAIL fl_sw3 got %0d exp 3", sw); end
    checks++; if (tr !== 16'd0) begin errors++; $display("FAIL fl_tr got %0d exp 0", tr); end
    pref_up = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (act !== 2'd2) begin errors++; $display("FAIL fl_hold%0d got %0d exp 2", k, act); end
    end
    pref_up = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (act !== 2'd2) begin errors++; $display("FAIL fl_back got %0d exp 2", act); end
    end
    checks++; if (sw !== 16'd3) begin errors++; $display("FAIL fl_nosw got %0d exp 3", sw); end
    pref_up = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (act !== 2'd2) begin errors++; $display("FAIL fl_reload%0d got %0d exp 2", k, act); end
    end
    tick();
    checks++; if (act !== 2'd1) begin errors++; $display("FAIL fl_pref got %0d exp 1", act); end
    checks++; if (sw !== 16'd4) begin errors++; $display("FAIL fl_sw4 got %0d exp 4", sw); end
  endtask

  task automatic test_both_down();
    pref_up = 1'b0; alt_up = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pref_bus = w(k == 0, 64'hF000 + 64'(k), k == 3);
      alt_bus  = w(k == 1, 64'hF100 + 64'(k), 1'b0);
      tick();
      checks++; if (act !== 2'd0) begin errors++; $display("FAIL bd_act%0d got %0d exp 0", k, act); end
      checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL bd_link%0d got %b exp 0", k, link_up); end
      checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL bd_bus%0d got %h exp 0", k, out_bus); end
    end
    checks++; if (sw !== 16'd4) begin errors++; $display("FAIL bd_sw got %0d exp 4", sw); end
    pref_bus = '0; alt_bus = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    EthernetRxBus e;
    pref_up = 1'b1;
    tick();
    checks++; if (act !== 2'd1 || sw !== 16'd5) begin errors++; $display("FAIL rm_sel got act=%0d sw=%0d exp 1 5", act, sw); end
    for (int i = 0; i < 3; i++) begin
      e = w(i == 0, 64'h5000 + 64'(i), 1'b0);
      pref_bus = e;
      tick();
      checks++; if (out_bus !== e) begin errors++; $display("FAIL rm_word%0d got %h exp %h", i, out_bus, e); end
    end
    pref_bus = w(1'b0, 64'h5003, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL rm_async_bus got %h exp 0", out_bus); end
    checks++; if (act !== 2'd0 || link_up !== 1'b0) begin errors++; $display("FAIL rm_async_sel got act=%0d link=%b exp 0 0", act, link_up); end
    checks++; if (sw !== 16'd0 || tr !== 16'd0) begin errors++; $display("FAIL rm_async_cnt got sw=%0d tr=%0d exp 0 0", sw, tr); end
    tick();
    pref_bus = w(1'b0, 64'h5004, 1'b0);
    tick();
    pref_bus = w(1'b0, 64'h5005, 1'b0);
    rst = 1'b0;
    tick();
    checks++; if (act !== 2'd1 || sw !== 16'd1) begin errors++; $display("FAIL rm_resume got act=%0d sw=%0d exp 1 1", act, sw); end
    checks++; if (out_bus !== EthernetRxBus'('0) || tr !== 16'd0) begin errors++; $display("FAIL rm_nodrop got %h tr=%0d exp 0 0", out_bus, tr); end
    for (int i = 6; i < 8; i++) begin
      pref_bus = w(1'b0, 64'h5000 + 64'(i), i == 7);
      tick();
      checks++; if (out_bus !== EthernetRxBus'('0)) begin errors++; $display("FAIL rm_supp%0d got %h exp 0", i, out_bus); end
    end
    pref_bus = '0;
    tick();
    e = w(1'b1, 64'h6000, 1'b1);
    pref_bus = e;
    tick();
    checks++; if (out_bus !== e) begin errors++; $display("FAIL rm_new got %h exp %h", out_bus, e); end
    pref_bus = '0;
    tick();
  endtask

  initial begin
    pref_bus = '0;
    alt_bus  = '0;
    test_reset();
    test_pref_frame();
    test_pref_drop();
    test_holdoff_frame();
    test_flap();
    test_both_down();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
